// File: rtl/led_blink_bank.sv
// Multi-channel LED blinker: one shared prescaler tick drives per-channel
// OFF/ON/BLINK/ONESHOT patterns, each configured through a single-cycle write port.
//
// mode    | meaning
// OFF     | led low, phase held
// ON      | led high, phase held
// BLINK   | led lit while phase < duty, phase wraps at period-1 on each tick
// ONESHOT | led lit while active, active drops after duty ticks and pulses done
module led_blink_bank #(
  parameter int CH       = 8,
  parameter int PRESCALE = 50000,
  parameter int PW       = 16
) (
  input  logic          clk,
  input  logic          aclr,
  input  logic          sync,
  input  logic          wr_en,
  input  logic [4:0]    wr_ch,
  input  logic [1:0]    wr_mode,
  input  logic [PW-1:0] wr_period,
  input  logic [PW-1:0] wr_duty,
  output logic          tick,
  output logic [CH-1:0] led,
  output logic [CH-1:0] done
);

  localparam int CW = $clog2(PRESCALE);

  typedef enum logic [1:0] {
    M_OFF     = 2'd0,
    M_ON      = 2'd1,
    M_BLINK   = 2'd2,
    M_ONESHOT = 2'd3
  } mode_t;

  logic [CW-1:0] pre_q;

  assign tick = (pre_q == CW'(PRESCALE - 1));

  always_ff @(posedge clk or negedge aclr) begin
    if (!aclr) begin
      pre_q <= '0;
    end else if (sync || tick) begin
      pre_q <= '0;
    end else begin
      pre_q <= pre_q + CW'(1);
    end
  end

  for (genvar g = 0; g < CH; g++) begin : g_ch
    mode_t         mode_q, mode_d;
    logic [PW-1:0] period_q, period_d;
    logic [PW-1:0] duty_q, duty_d;
    logic [PW-1:0] phase_q, phase_d;
    logic          active_q, active_d;
    logic          led_q, done_q;
    logic          lit, fin, wr_sel;

    // Channel index match implies wr_ch < CH, so out-of-range writes hit nobody.
    assign wr_sel = wr_en && (wr_ch == 5'(g));

    always_comb begin
      lit = 1'b0;
      case (mode_q)
        M_OFF:     lit = 1'b0;
        M_ON:      lit = 1'b1;
        M_BLINK:   lit = (period_q != '0) && (phase_q < duty_q);
        M_ONESHOT: lit = active_q;
        default:   lit = 1'b0;
      endcase
    end

    always_comb begin
      mode_d   = mode_q;
      period_d = period_q;
      duty_d   = duty_q;
      phase_d  = phase_q;
      active_d = active_q;
      fin      = 1'b0;
      if (wr_sel) begin
        mode_d   = mode_t'(wr_mode);
        period_d = wr_period;
        duty_d   = wr_duty;
        phase_d  = '0;
        active_d = (wr_mode == 2'd3) && (wr_duty != '0);
      end else if (sync) begin
        phase_d = '0;
      end else if (tick) begin
        case (mode_q)
          M_BLINK: begin
            if (period_q == '0 || phase_q >= period_q - PW'(1)) begin
              phase_d = '0;
            end else begin
              phase_d = phase_q + PW'(1);
            end
          end
          M_ONESHOT: begin
            if (active_q) begin
              if (phase_q == duty_q - PW'(1)) begin
                active_d = 1'b0;
                phase_d  = '0;
                fin      = 1'b1;
              end else begin
                phase_d = phase_q + PW'(1);
              end
            end
          end
          default: ;
        endcase
      end
    end

    always_ff @(posedge clk or negedge aclr) begin
      if (!aclr) begin
        mode_q   <= M_OFF;
        period_q <= '0;
        duty_q   <= '0;
        phase_q  <= '0;
        active_q <= 1'b0;
        led_q    <= 1'b0;
        done_q   <= 1'b0;
      end else begin
        mode_q   <= mode_d;
        period_q <= period_d;
        duty_q   <= duty_d;
        phase_q  <= phase_d;
        active_q <= active_d;
        led_q    <= lit;
        done_q   <= fin;
      end
    end

    assign led[g]  = led_q;
    assign done[g] = done_q;
  end

endmodule

// File: tb/tb_led_blink_bank.sv
// Directed bench for led_blink_bank with PRESCALE=4, CH=4, PW=8; outputs are
// sampled on the falling edge and compared against hand-derived sequences.
module tb_led_blink_bank;

  localparam int CH       = 4;
  localparam int PRESCALE = 4;
  localparam int PW       = 8;

  logic          clk = 1'b0;
  logic          aclr = 1'b0;
  logic          sync = 1'b0;
  logic          wr_en = 1'b0;
  logic [4:0]    wr_ch = '0;
  logic [1:0]    wr_mode = '0;
  logic [PW-1:0] wr_period = '0;
  logic [PW-1:0] wr_duty = '0;
  logic          tick;
  logic [CH-1:0] led;
  logic [CH-1:0] done;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  led_blink_bank #(.CH(CH), .PRESCALE(PRESCALE), .PW(PW)) dut (
    .clk       (clk),
    .aclr      (aclr),
    .sync      (sync),
    .wr_en     (wr_en),
    .wr_ch     (wr_ch),
    .wr_mode   (wr_mode),
    .wr_period (wr_period),
    .wr_duty   (wr_duty),
    .tick      (tick),
    .led       (led),
    .done      (done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic wr(input int ch, input int mode, input int p, input int d);
    wr_en     = 1'b1;
    wr_ch     = 5'(ch);
    wr_mode   = 2'(mode);
    wr_period = PW'(p);
    wr_duty   = PW'(d);
    @(posedge clk);
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic wait_tick(input string tag);
    int k = 0;
    while (tick !== 1'b1 && k < 10) begin
      cyc(1);
      k++;
    end
    chk(tag, 32'(tick), 32'd1);
  endtask

  initial begin
    int nd;

    // reset state and prescaler cadence
    #1;
    chk("rst_led", 32'(led), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_tick", 32'(tick), 32'd0);
    @(negedge clk);
    aclr = 1'b1;
    cyc(2);
    chk("tick_c2", 32'(tick), 32'd0);
    cyc(1);
    chk("tick_first", 32'(tick), 32'd1);
    cyc(1);
    chk("tick_after", 32'(tick), 32'd0);
    cyc(3);
    chk("tick_second", 32'(tick), 32'd1);

    // ch1 duty>=period, ch2 period 0, invalid channel 7
    wr(1, 2, 3, 5);
    wr(2, 2, 0, 2);
    wr(7, 1, 0, 0);
    chk("cfg_led", 32'(led), 32'h2);

    // ch0 written in the tick cycle: phase must start at 0
    wait_tick("tick_before_ch0");
    wr(0, 2, 4, 1);
    chk("ch0_wr_edge", 32'(led[0]), 32'd0);
    for (int i = 0; i <= 16; i++) begin
      cyc(1);
      chk($sformatf("blink_led_%0d", i), 32'(led), {28'd0, 3'b001, 1'(((i % 16) < 4))});
    end

    // oneshot ch3 duty 3, written right after a tick
    wait_tick("tick_before_os");
    cyc(1);
    wr(3, 3, 0, 3);
    for (int i = 0; i <= 14; i++) begin
      chk($sformatf("os_led_%0d", i), 32'(led[3]), 32'((i >= 1) && (i <= 11)));
      chk($sformatf("os_done_%0d", i), 32'(done[3]), 32'(i == 11));
      cyc(1);
    end

    // rewrite mid-pulse: exactly one done
    nd = 0;
    wr(3, 3, 9, 3);
    repeat (5) begin
      cyc(1);
      nd += int'(done[3]);
    end
    wr(3, 3, 9, 3);
    nd += int'(done[3]);
    repeat (20) begin
      cyc(1);
      nd += int'(done[3]);
    end
    chk("os_restart_done_cnt", 32'(nd), 32'd1);
    chk("os_restart_led_end", 32'(led[3]), 32'd0);

    // sync aligns ch0/ch1 with different phases
    wr(0, 2, 4, 2);
    cyc(8);
    wr(1, 2, 4, 2);
    cyc(3);
    sync = 1'b1;
    @(posedge clk);
    @(negedge clk);
    sync = 1'b0;
    for (int i = 0; i <= 16; i++) begin
      chk($sformatf("sync_tick_%0d", i), 32'(tick), 32'((i % 4) == 3));
      if (i >= 1) begin
        chk($sformatf("sync_led0_%0d", i), 32'(led[0]), 32'((((i - 1) / 4) % 4) < 2));
        chk($sformatf("sync_led1_%0d", i), 32'(led[1]), 32'((((i - 1) / 4) % 4) < 2));
      end
      cyc(1);
    end
    chk("ch2_period0", 32'(led[2]), 32'd0);

    // mode switching on ch2
    wr(2, 1, 0, 0);
    chk("on_wr_edge", 32'(led[2]), 32'd0);
    cyc(1);
    chk("on_led", 32'(led[2]), 32'd1);
    wr(2, 0, 0, 0);
    cyc(1);
    chk("off_led", 32'(led[2]), 32'd0);
    wr(2, 1, 0, 0);
    cyc(1);
    chk("on_again", 32'(led[2]), 32'd1);
    wr(2, 2, 4, 1);
    cyc(1);
    chk("on_to_blink", 32'(led[2]), 32'd1);

    // asynchronous reset mid-operation
    wr(1, 1, 0, 0);
    cyc(1);
    wait_tick("tick_before_rst");
    chk("pre_rst_led1", 32'(led[1]), 32'd1);
    #2;
    aclr = 1'b0;
    #1;
    chk("mid_rst_led", 32'(led), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    chk("mid_rst_tick", 32'(tick), 32'd0);
    @(negedge clk);
    aclr = 1'b1;
    cyc(3);
    chk("rst2_tick_first", 32'(tick), 32'd1);
    cyc(4);
    chk("rst2_tick_second", 32'(tick), 32'd1);
    chk("rst2_cfg_lost", 32'(led), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
